// File: rtl/bias_relu_sequencer_pkg.sv
// Shared types, constants and sign-magnitude helpers for bias_relu_sequencer.
// Arithmetic helpers are sized for 16-bit sign-magnitude data.
package bias_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int SM_W  = 16;        // sign-magnitude width
  localparam int TC_W  = SM_W + 1;  // two's complement operand width
  localparam int SUM_W = SM_W + 2;  // sum width, cannot overflow

  localparam logic [SM_W-2:0] SAT_MAG = 15'h7FFF;

  // Sign-magnitude to two's complement; negative zero maps to 0.
  function automatic logic [TC_W-1:0] sm2tc(input logic [SM_W-1:0] sm);
    logic [TC_W-1:0] mag;
    mag = {2'b00, sm[SM_W-2:0]};
    if (sm[SM_W-1]) begin
      sm2tc = ~mag + 17'd1;
    end else begin
      sm2tc = mag;
    end
  endfunction

  // Two's complement sum to saturated sign-magnitude; zero is always +0.
  function automatic logic [SM_W-1:0] tc2sm_sat(input logic [SUM_W-1:0] s);
    logic [SUM_W-1:0] mag;
    logic [SM_W-2:0]  mag_sat;
    if (s[SUM_W-1]) begin
      mag = ~s + 18'd1;
    end else begin
      mag = s;
    end
    if (mag > {3'b000, SAT_MAG}) begin
      mag_sat = SAT_MAG;
    end else begin
      mag_sat = mag[SM_W-2:0];
    end
    if (mag_sat == 15'd0) begin
      tc2sm_sat = 16'h0000;
    end else begin
      tc2sm_sat = {s[SUM_W-1], mag_sat};
    end
  endfunction

endpackage

// File: rtl/bias_relu_sequencer_if.sv
// Input and output streams of bias_relu_sequencer.
// master = producer/consumer side, slave = the sequencer itself.
interface bias_relu_sequencer_if #(
  parameter int DW = 16,
  parameter int CH = 128
);
  localparam int CW = (CH > 1) ? $clog2(CH) : 1;

  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ch;
  logic          out_last;
  logic          out_valid;
  logic          out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_ch, out_last, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_ch, out_last, out_valid
  );
endinterface

// File: rtl/bias_relu_sequencer_sm_bias_adder.sv
// Output stage: adds converted operands, saturates, optionally applies ReLU
// and registers the sign-magnitude result. Optional macro: BIAS_RELU_EN.
module sm_bias_adder
  import bias_seq_pkg::*;
#(
  parameter int CW = 7
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_en,
  input  logic            i_valid,
  input  logic [TC_W-1:0] i_a,
  input  logic [TC_W-1:0] i_b,
  input  logic [CW-1:0]   i_ch,
  input  logic            i_last,
  output logic            o_valid,
  output logic [SM_W-1:0] o_data,
  output logic [CW-1:0]   o_ch,
  output logic            o_last
);

  logic [SUM_W-1:0] w_sum;
  logic [SM_W-1:0]  w_sat;
  logic [SM_W-1:0]  w_res;

  // Sign-extend both operands, add, saturate and normalise to sign-magnitude.
  always_comb begin
    w_sum = {i_a[TC_W-1], i_a} + {i_b[TC_W-1], i_b};
    w_sat = tc2sm_sat(w_sum);
`ifdef BIAS_RELU_EN
    if (w_sat[SM_W-1]) begin
      w_res = 16'h0000;
    end else begin
      w_res = w_sat;
    end
`else
    w_res = w_sat;
`endif
  end

  // Output register; holds while downstream stalls, loads only valid beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid <= 1'b0;
      o_data  <= 16'h0000;
      o_ch    <= '0;
      o_last  <= 1'b0;
    end else if (i_en) begin
      o_valid <= i_valid;
      if (i_valid) begin
        o_data <= w_res;
        o_ch   <= i_ch;
        o_last <= i_last;
      end
    end
  end

endmodule

// File: rtl/bias_relu_sequencer.sv
// bias_relu_sequencer: walks the per-channel bias ROM in step with the
// channel-fastest input stream, adds bias with saturation (ReLU when
// BIAS_RELU_EN is defined) and emits results through a two-stage pipeline.
module bias_relu_sequencer
  import bias_seq_pkg::*;
#(
  parameter int CH      = 128,
  parameter int NUM_PIX = 729,
  parameter int DW      = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  input  logic [DW-1:0]           bias_mem [0:CH-1],
  bias_relu_sequencer_if.slave    io
);

  localparam int CW = (CH > 1) ? $clog2(CH) : 1;
  localparam int PW = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1;

  state_t          r_state;
  logic [CW-1:0]   r_ch_cnt;
  logic [PW-1:0]   r_pix_cnt;
  logic            r_busy;
  logic            r_done;
  logic            r_s1_valid;
  logic [TC_W-1:0] r_s1_a;
  logic [TC_W-1:0] r_s1_b;
  logic [CW-1:0]   r_s1_ch;
  logic            r_s1_last;

  logic w_advance;
  logic w_s1_en;
  logic w_in_ready;
  logic w_in_hs;
  logic w_ch_last;
  logic w_in_last;
  logic w_out_last_hs;

  // An empty s1 may fill even while the output stage is stalled.
  assign w_advance     = !io.out_valid || io.out_ready;
  assign w_s1_en       = w_advance || !r_s1_valid;
  assign w_in_ready    = (r_state == RUN) && w_s1_en;
  assign w_in_hs       = io.in_valid && w_in_ready;
  assign w_ch_last     = (r_ch_cnt == CW'(CH - 1));
  assign w_in_last     = w_ch_last && (r_pix_cnt == PW'(NUM_PIX - 1));
  assign w_out_last_hs = io.out_valid && io.out_ready && io.out_last;

  assign io.in_ready = w_in_ready;
  assign busy        = r_busy;
  assign done        = r_done;

  // Layer FSM with channel/pixel counters and registered busy/done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_ch_cnt  <= '0;
      r_pix_cnt <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state   <= RUN;
            r_busy    <= 1'b1;
            r_ch_cnt  <= '0;
            r_pix_cnt <= '0;
          end
        end
        RUN: begin
          if (w_in_hs) begin
            if (w_in_last) begin
              r_state   <= DRAIN;
              r_ch_cnt  <= '0;
              r_pix_cnt <= '0;
            end else if (w_ch_last) begin
              r_ch_cnt  <= '0;
              r_pix_cnt <= r_pix_cnt + PW'(1);
            end else begin
              r_ch_cnt  <= r_ch_cnt + CW'(1);
            end
          end
        end
        DRAIN: begin
          if (w_out_last_hs) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // Stage 1: capture converted operands with their channel and last tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_ch    <= '0;
      r_s1_last  <= 1'b0;
    end else if (w_s1_en) begin
      r_s1_valid <= w_in_hs;
      if (w_in_hs) begin
        r_s1_a    <= sm2tc(io.in_data);
        r_s1_b    <= sm2tc(bias_mem[r_ch_cnt]);
        r_s1_ch   <= r_ch_cnt;
        r_s1_last <= w_in_last;
      end
    end
  end

  sm_bias_adder #(.CW(CW)) u_s2 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (w_advance),
    .i_valid (r_s1_valid),
    .i_a     (r_s1_a),
    .i_b     (r_s1_b),
    .i_ch    (r_s1_ch),
    .i_last  (r_s1_last),
    .o_valid (io.out_valid),
    .o_data  (io.out_data),
    .o_ch    (io.out_ch),
    .o_last  (io.out_last)
  );

endmodule

// File: tb/tb_bias_relu_sequencer.sv
// Directed bench for bias_relu_sequencer with CH=4, NUM_PIX=3.
// Expected results are hand-computed for both BIAS_RELU_EN settings.
module tb_bias_relu_sequencer;

  localparam int CH = 4;
  localparam int NP = 3;
  localparam int NB = CH * NP;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy;
  logic        done;
  logic [15:0] bias_mem [0:CH-1];
  logic        bp_en = 1'b0;
  logic        mon_clr = 1'b0;

  bias_relu_sequencer_if #(.DW(16), .CH(CH)) io ();

  bias_relu_sequencer #(.CH(CH), .NUM_PIX(NP), .DW(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .bias_mem (bias_mem),
    .io       (io)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] vin  [0:NB-1];
  logic [15:0] vexp [0:NB-1];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Monitor state (sampled on the falling edge)
  int          cyc = 0;
  int          in_cnt = 0;
  int          out_cnt = 0;
  int          done_cnt = 0;
  int          first_in_cyc = 0;
  int          first_out_cyc = 0;
  int          last_cyc = 0;
  int          done_cyc = 0;
  logic        busy_at_last = 1'b0;
  logic        busy_at_done = 1'b1;
  logic        stall_prev = 1'b0;
  logic [15:0] held_data = 16'h0;
  logic [1:0]  held_ch = 2'd0;
  logic [15:0] got_data [0:15];
  logic [1:0]  got_ch   [0:15];
  logic        got_last [0:15];

  // Falling-edge monitor: records handshakes, checks stall stability and in_ready
  always @(negedge clk) begin
    cyc++;
    if (mon_clr) begin
      done_cnt = 0;
    end
    if (!rst_n || mon_clr) begin
      in_cnt = 0;
      out_cnt = 0;
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check_eq("stall_valid", {31'd0, io.out_valid}, 32'd1);
        check_eq("stall_data", {16'd0, io.out_data}, {16'd0, held_data});
        check_eq("stall_ch", {30'd0, io.out_ch}, {30'd0, held_ch});
      end
      if ((in_cnt - out_cnt) == 2 && io.out_valid && !io.out_ready)
        check_eq("in_ready_full", {31'd0, io.in_ready}, 32'd0);
      if (io.in_valid && io.in_ready) begin
        if (in_cnt == 0) first_in_cyc = cyc;
        in_cnt++;
      end
      if (io.out_valid && io.out_ready) begin
        if (out_cnt == 0) first_out_cyc = cyc;
        if (out_cnt < 16) begin
          got_data[out_cnt] = io.out_data;
          got_ch[out_cnt]   = io.out_ch;
          got_last[out_cnt] = io.out_last;
        end
        if (io.out_last) begin
          last_cyc = cyc;
          busy_at_last = busy;
        end
        out_cnt++;
      end
      stall_prev = io.out_valid && !io.out_ready;
      held_data  = io.out_data;
      held_ch    = io.out_ch;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      busy_at_done = busy;
    end
  end

  // Downstream ready: always 1, or random when backpressure is enabled
  initial io.out_ready = 1'b1;
  always @(posedge clk) begin
    #1;
    io.out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic clear_mon();
    @(posedge clk); #1 mon_clr = 1'b1;
    @(posedge clk); #1 mon_clr = 1'b0;
  endtask

  task automatic do_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Present n beats in order; a stray start is raised on beat 5 (must be ignored)
  task automatic drive_beats(input int n);
    logic acc;
    for (int i = 0; i < n; i++) begin
      io.in_valid = 1'b1;
      io.in_data  = vin[i];
      start       = (i == 5);
      acc = 1'b0;
      for (int t = 0; t < 200; t++) begin
        @(negedge clk);
        if (io.in_ready) begin
          acc = 1'b1;
          break;
        end
      end
      if (!acc) check_eq($sformatf("in_accept%0d", i), 32'd0, 32'd1);
      @(posedge clk); #1;
    end
    io.in_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int k = 0; k < 600; k++) begin
      if (done_cnt != 0) break;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic check_run(input string pfx);
    check_eq({pfx, "_count"}, out_cnt, NB);
    for (int i = 0; i < NB; i++) begin
      check_eq($sformatf("%s_data%0d", pfx, i), {16'd0, got_data[i]}, {16'd0, vexp[i]});
      check_eq($sformatf("%s_ch%0d", pfx, i), {30'd0, got_ch[i]}, i % CH);
      check_eq($sformatf("%s_last%0d", pfx, i), {31'd0, got_last[i]}, (i == NB - 1) ? 32'd1 : 32'd0);
    end
    check_eq({pfx, "_done_cnt"}, done_cnt, 32'd1);
    check_eq({pfx, "_done_cyc"}, done_cyc, last_cyc + 1);
    check_eq({pfx, "_busy_last"}, {31'd0, busy_at_last}, 32'd1);
    check_eq({pfx, "_busy_done"}, {31'd0, busy_at_done}, 32'd0);
    check_eq({pfx, "_busy_idle"}, {31'd0, busy}, 32'd0);
    check_eq({pfx, "_rdy_idle"}, {31'd0, io.in_ready}, 32'd0);
  endtask

  task automatic check_reset_vals(input string pfx);
    check_eq({pfx, "_out_valid"}, {31'd0, io.out_valid}, 32'd0);
    check_eq({pfx, "_out_data"}, {16'd0, io.out_data}, 32'd0);
    check_eq({pfx, "_out_ch"}, {30'd0, io.out_ch}, 32'd0);
    check_eq({pfx, "_out_last"}, {31'd0, io.out_last}, 32'd0);
    check_eq({pfx, "_in_ready"}, {31'd0, io.in_ready}, 32'd0);
    check_eq({pfx, "_busy"}, {31'd0, busy}, 32'd0);
    check_eq({pfx, "_done"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    io.in_valid = 1'b0;
    io.in_data  = 16'h0000;
    bias_mem[0] = 16'h8006;  // -6
    bias_mem[1] = 16'h0020;  // +32
    bias_mem[2] = 16'h8020;  // -32
    bias_mem[3] = 16'h8000;  // negative zero
    vin = '{16'h000A, 16'h7FF0, 16'hFFF0, 16'h8000,
            16'h0002, 16'h8020, 16'h0020, 16'h1234,
            16'h8006, 16'h0000, 16'h0100, 16'h9234};
`ifdef BIAS_RELU_EN
    vexp = '{16'h0004, 16'h7FFF, 16'h0000, 16'h0000,
             16'h0000, 16'h0000, 16'h0000, 16'h1234,
             16'h0000, 16'h0020, 16'h00E0, 16'h0000};
`else
    vexp = '{16'h0004, 16'h7FFF, 16'hFFFF, 16'h0000,
             16'h8004, 16'h0000, 16'h0000, 16'h1234,
             16'h800C, 16'h0020, 16'h00E0, 16'h9234};
`endif

    // Reset and idle
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_vals("rst");

    // Full run, out_ready held high
    clear_mon();
    do_start();
    drive_beats(NB);
    wait_done();
    check_run("run1");
    check_eq("run1_latency", first_out_cyc - first_in_cyc, 32'd2);

    // Abort mid-run at pix_cnt=1
    clear_mon();
    do_start();
    drive_beats(6);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("abort");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_eq("abort_no_done", done_cnt, 32'd0);
    check_reset_vals("abort_idle");

    // Full run after abort, with random backpressure
    clear_mon();
    bp_en = 1'b1;
    do_start();
    drive_beats(NB);
    wait_done();
    bp_en = 1'b0;
    check_run("run_bp");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
